// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M-style multiply/divide, one bit per cycle.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int CNTW = $clog2(XLEN)
) (
    input  logic            I_clk,
    input  logic            I_rst,
    input  logic            I_start,
    input  logic [2:0]      I_op,
    input  logic [XLEN-1:0] I_data1,
    input  logic [XLEN-1:0] I_data2,
    input  logic            I_flush,
    output logic            O_ready,
    output logic            O_valid,
    output logic [XLEN-1:0] O_result
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t            state, state_next;
    logic [2:0]        op;
    logic              sgn;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc, acc_next, prod_fix;
    logic [CNTW-1:0]   cnt;
    logic [XLEN:0]     sum, shifted, trial;
    logic [XLEN-1:0]   mag1, mag2, fast_res, div_val, final_res;
    logic              s1, s2, by_zero, ovf, fast, accept, last;
    assign s1       = I_data1[XLEN-1] & (I_op == 3'b001 | I_op == 3'b010 | (I_op[2] & ~I_op[0]));
    assign s2       = I_data2[XLEN-1] & (I_op == 3'b001 | (I_op[2] & ~I_op[0]));
    assign mag1     = s1 ? -I_data1 : I_data1;
    assign mag2     = s2 ? -I_data2 : I_data2;
    assign by_zero  = I_op[2] && I_data2 == '0;
    assign ovf      = I_op[2] && !I_op[0] && I_data1 == {1'b1, {(XLEN-1){1'b0}}} && I_data2 == '1;
    assign fast     = by_zero | ovf;
    assign fast_res = by_zero ? (I_op[1] ? I_data1 : '1) : (I_op[1] ? '0 : I_data1);
    assign accept   = state == IDLE && I_start && !I_flush;
    assign last     = cnt == CNTW'(XLEN-1);
    // acc holds {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
        sum       = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, acc[0] ? opnd : '0};
        shifted   = acc[2*XLEN-1:XLEN-1];
        trial     = shifted - {1'b0, opnd};
        acc_next  = op[2] ? (trial[XLEN] ? {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                         : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                          : {sum, acc[XLEN-1:1]};
        prod_fix  = sgn ? -acc_next : acc_next;
        div_val   = op[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
        final_res = op[2] ? (sgn ? -div_val : div_val)
                          : (op[1:0] == 2'b00 ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);
    end
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = accept ? (fast ? DONE : BUSY) : IDLE;
            BUSY:    state_next = I_flush ? IDLE : (last ? DONE : BUSY);
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge I_clk) begin
        if (I_rst) state <= IDLE;
        else       state <= state_next;
    end
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            op       <= '0;
            sgn      <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            cnt      <= '0;
            O_result <= '0;
        end else if (accept) begin
            op   <= I_op;
            sgn  <= I_op == 3'b110 ? s1 : s1 ^ s2;
            opnd <= I_op[2] ? mag2 : mag1;
            acc  <= {{XLEN{1'b0}}, I_op[2] ? mag1 : mag2};
            cnt  <= '0;
            if (fast) O_result <= fast_res;
        end else if (state == BUSY && !I_flush) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (last) O_result <= final_res;
        end
    end
    assign O_ready = state == IDLE;
    assign O_valid = state == DONE;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a queue scoreboard checked by a separate monitor.
module tb_muldiv_unit;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] d1 = '0, d2 = '0;
    logic        ready, valid;
    logic [31:0] result;
    int          checks = 0, errors = 0, cyc = 0, id = 0;

    typedef struct {logic [31:0] res; int cyc; int id;} exp_t;
    exp_t sb[$];

    muldiv_unit #(.XLEN(32)) dut (
        .I_clk(clk), .I_rst(rst), .I_start(start), .I_op(op),
        .I_data1(d1), .I_data2(d2), .I_flush(flush),
        .O_ready(ready), .O_valid(valid), .O_result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: result %h at cycle %0d", result, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("result_%0d", e.id), result, e.res);
                check($sformatf("latency_%0d", e.id), 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; d1 = a; d2 = b; start = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int  bad = 0;
        bit  done = 0;
        #1;
        for (int i = 0; i < 45 && !done; i++) begin
            if (sb.size() == 0) done = 1;
            else begin
                if (ready) bad++;
                @(negedge clk);
                #1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got pending %0d expected 0", name, sb.size());
            sb.delete();
        end
        check({name, "_ready_low"}, 32'(bad), 32'd0);
        @(negedge clk);
        check({name, "_ready_back"}, 32'(ready), 32'd1);
    endtask

    task automatic run(input string name, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit fast);
        exp_t e;
        @(negedge clk);
        drive(o, a, b);
        e.res = exp; e.cyc = cyc + 1 + (fast ? 0 : 32); e.id = id++;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0; d1 = $urandom; d2 = $urandom; op = 3'($urandom);
        wait_done(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_result", result, 32'd0);

        run("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0);
        run("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 0);
        run("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        run("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0);
        run("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0);
        run("divu",   3'b101, 32'd100,      32'd7,        32'd14,       0);
        run("remu",   3'b111, 32'd100,      32'd7,        32'd2,        0);
        run("divu_z", 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run("rem_z",  3'b110, 32'd5,        32'd0,        32'd5,        1);
        run("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

        // start pulse while busy is ignored
        @(negedge clk);
        drive(3'b000, 32'd3, 32'd4);
        e.res = 32'd12; e.cyc = cyc + 33; e.id = id++;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        drive(3'b000, 32'd5, 32'd5);
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore");

        // flush mid-operation: no pulse, result held
        @(negedge clk);
        drive(3'b000, 32'd6, 32'd7);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", 32'(ready), 32'd1);
        check("flush_valid", 32'(valid), 32'd0);
        check("flush_result", result, 32'd12);
        repeat (40) @(negedge clk);
        check("flush_result_held", result, 32'd12);

        // reset mid-divide
        @(negedge clk);
        drive(3'b100, 32'd1000, 32'hFFFFFFFD);
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_result", result, 32'd0);
        run("divu_after_rst", 3'b101, 32'd9, 32'd3, 32'd3, 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit implementing the RV32M-style MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operations.
- Generalised to XLEN-bit operands; processes one bit per cycle (shift-add multiply, restoring divide).
- Sits beside the combinational ALU in the execute stage and stalls the pipeline through a start/ready/valid handshake.
- Fixed-latency normal path; single-cycle fast path for divide-by-zero and signed overflow.

Parameters:
- XLEN, 32, operand and result width in bits (any even value >= 8).
- CNTW, $clog2(XLEN), width of the iteration counter.

Ports:
- I_clk  input  1  clock; all state changes on the rising edge.
- I_rst  input  1  reset, synchronous, active-high.
- I_start  input  1  request; sampled only while O_ready=1.
- I_op  input  3  operation, funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- I_data1  input  XLEN  rs1 operand (dividend or multiplicand).
- I_data2  input  XLEN  rs2 operand (divisor or multiplier).
- I_flush  input  1  abort any in-flight operation.
- O_ready  output  1  unit is idle and can accept I_start.
- O_valid  output  1  one-cycle pulse; O_result is valid.
- O_result  output  XLEN  registered result; held until the next result is written.

Behaviour:
- Reset (I_rst=1 at an edge): state IDLE, O_ready=1, O_valid=0, O_result=0, counter=0, internal registers=0. Reset mid-operation discards the operation with no O_valid pulse.
- States:
  - IDLE: O_ready=1. If I_start=1 at an edge, latch I_op, the operand magnitudes and the result sign, then go to BUSY with counter=0. The fast-path cases below go to DONE instead.
  - BUSY: O_ready=0. Perform one iteration per cycle and increment the counter. On the edge where counter==XLEN-1, the final iteration completes; apply the sign correction, write O_result, and go to DONE.
  - DONE: O_valid=1 for exactly one cycle, O_ready=0, then return to IDLE unconditionally.
- Latency:
  - Normal path: start sampled at edge E; O_valid is high during the cycle following edge E+XLEN, i.e. XLEN+1 cycles after acceptance. O_ready returns high one cycle later.
  - Fast path: O_valid is high in the cycle after edge E (1 cycle).
- Back-to-back: I_start is accepted only in IDLE. I_start in BUSY or DONE is ignored, not queued.
- Multiply:
  - Full 2*XLEN-bit product computed on magnitudes.
  - MUL returns the low XLEN bits.
  - MULH/MULHSU/MULHU return the high XLEN bits.
  - Signedness:
    - MULH: both operands signed.
    - MULHSU: I_data1 signed, I_data2 unsigned.
    - MULHU/MUL: unsigned magnitudes. MUL low bits are identical under signed or unsigned interpretation.
  - Sign correction: two's-complement negate the full 2*XLEN product when the result sign is 1, before selecting high or low bits.
- Divide:
  - Restoring division on magnitudes; DIV/REM are signed, DIVU/REMU unsigned.
  - Quotient sign is the XOR of the operand signs.
  - Remainder sign equals the dividend sign.
  - Quotient rounds toward zero.
- Fast path, decided at acceptance:
  - Divisor==0: DIV/DIVU give all ones; REM/REMU give I_data1.
  - Signed overflow (DIV/REM, I_data1 = most-negative value, I_data2 = all ones): DIV gives I_data1; REM gives 0.
- Flush:
  - I_flush=1 at an edge in BUSY or DONE: go to IDLE, no O_valid pulse (a DONE-cycle pulse already in progress completes that cycle only), O_result unchanged.
  - Reset has priority over flush.
  - In IDLE, flush has priority over start: a simultaneous I_start is dropped.
- Operands are latched at acceptance; changes on I_data1/I_data2/I_op during BUSY have no effect.
- Most-negative operands are handled by unsigned-magnitude arithmetic, with no overflow in the multiply path.

Test Plan:
- MUL, XLEN=32: 7 * 0xFFFFFFFD -> O_result=0xFFFFFFEB, O_valid exactly 33 cycles after acceptance, one cycle wide; O_ready low during BUSY/DONE.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with O_valid on the cycle after acceptance; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, also 1-cycle.
- Start MUL 3*4, pulse I_start with new operands at cycle 10 -> ignored, result 12. Then issue I_flush at cycle 5 of a second op -> no O_valid, O_ready=1 next cycle, O_result stays 12.
- Assert I_rst at cycle 20 of a DIV -> next cycle O_ready=1, O_valid=0, O_result=0. A fresh DIVU 9/3 then returns 3 at the normal latency.
